// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU-side memory/IO responder.
// Holds the IO window decode and register offsets.
package mem_io_responder_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] byte_t;

    localparam logic [1:0] IO_BASE = 2'b11;
    localparam logic [2:0] IO_UART = 3'd0;
    localparam logic [2:0] IO_CLK  = 3'd4;

    function automatic logic is_io(input logic [1:0] hi);
        return hi == IO_BASE;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide synchronous FIFO with same-cycle push/pop.
// A pop on a full FIFO frees the slot for a simultaneous push.
module byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  byte_t       din,
    output byte_t       dout,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count,
    output logic [AW:0] count_next,
    output logic        overflow
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    byte_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    always_comb begin
        empty = (cnt_q == '0);
        full = (cnt_q == FULL_CNT);
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        overflow = push && !do_push;
        wr_d = do_push ? wr_q + PTR_ONE : wr_q;
        rd_d = do_pop ? rd_q + PTR_ONE : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + ONE;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - ONE;
        end
        count = cnt_q;
        count_next = cnt_d;
        dout = mem_q[rd_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory port responder: RAM plus UART FIFOs, cycle
// counter and halt flag in the 0x3xxxx IO window.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        rdy_out,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic        err_overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] RDY_MAX = (FIFO_AW+1)'(DEPTH - 2);

    byte_t ram_q [2**RAM_AW];
    byte_t ram_rd_q;

    logic io, reg_hit, uart_sel, clk_sel;
    logic [2:0] io_off;
    byte_t io_rdata;

    logic rx_pop, rx_empty, rx_full, rx_ovf;
    byte_t rx_dout;
    logic [FIFO_AW:0] rx_cnt, rx_cnt_nx;

    logic tx_push, tx_pop, tx_empty, tx_full, tx_ovf;
    byte_t tx_din, tx_dout;
    logic [FIFO_AW:0] tx_cnt, tx_cnt_nx;

    byte_t mem_din_q, mem_din_d;
    byte_t rd_io_q, rd_io_d;
    logic rd_sel_q, rd_sel_d;
    logic rd_vld_q, rd_vld_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] snap_q, snap_d;
    logic halt_q, halt_d;
    logic err_q, err_d;
    logic rdy_q, rdy_d;

    always_comb begin
        io = is_io(mem_a[17:16]);
        io_off = mem_a[2:0];
        reg_hit = io && (mem_a[15:3] == '0);
        uart_sel = reg_hit && (io_off == IO_UART);
        clk_sel = reg_hit && (io_off == IO_CLK);
        rx_pop = uart_sel && !mem_wr;
        // A zero byte is the end marker, only the halt write may send it
        tx_push = mem_wr && (clk_sel || (uart_sel && mem_dout != 8'h00));
        tx_din = clk_sel ? 8'h00 : mem_dout;
        tx_pop = !tx_empty && tx_ready;
        io_rdata = 8'h00;
        if (reg_hit && !mem_wr) begin
            case (io_off)
                IO_UART: io_rdata = rx_empty ? 8'h00 : rx_dout;
                IO_CLK:  io_rdata = cyc_q[7:0];
                3'd5:    io_rdata = snap_q[15:8];
                3'd6:    io_rdata = snap_q[23:16];
                3'd7:    io_rdata = snap_q[31:24];
                default: io_rdata = 8'h00;
            endcase
        end
    end

    always_comb begin
        rd_io_d = io_rdata;
        rd_sel_d = io;
        rd_vld_d = 1'b1;
        if (!rd_vld_q) begin
            mem_din_d = 8'h00;
        end else begin
            mem_din_d = rd_sel_q ? rd_io_q : ram_rd_q;
        end
        cyc_d = cyc_q + 32'd1;
        snap_d = (clk_sel && !mem_wr) ? cyc_q : snap_q;
        halt_d = halt_q | (mem_wr && clk_sel);
        err_d = err_q | rx_ovf | tx_ovf;
        rdy_d = (tx_cnt_nx <= RDY_MAX);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din_q <= 8'h00;
            rd_io_q <= 8'h00;
            rd_sel_q <= 1'b0;
            rd_vld_q <= 1'b0;
            cyc_q <= 32'd0;
            snap_q <= 32'd0;
            halt_q <= 1'b0;
            err_q <= 1'b0;
            rdy_q <= 1'b1;
        end else begin
            mem_din_q <= mem_din_d;
            rd_io_q <= rd_io_d;
            rd_sel_q <= rd_sel_d;
            rd_vld_q <= rd_vld_d;
            cyc_q <= cyc_d;
            snap_q <= snap_d;
            halt_q <= halt_d;
            err_q <= err_d;
            rdy_q <= rdy_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_wr && !io) begin
            ram_q[mem_a[RAM_AW-1:0]] <= mem_dout;
        end
        ram_rd_q <= ram_q[mem_a[RAM_AW-1:0]];
    end

    byte_fifo #(.AW(FIFO_AW)) u_rx (
        .clk(clk_in),
        .rst(rst_in),
        .push(rx_valid),
        .pop(rx_pop),
        .din(rx_data),
        .dout(rx_dout),
        .empty(rx_empty),
        .full(rx_full),
        .count(rx_cnt),
        .count_next(rx_cnt_nx),
        .overflow(rx_ovf)
    );

    byte_fifo #(.AW(FIFO_AW)) u_tx (
        .clk(clk_in),
        .rst(rst_in),
        .push(tx_push),
        .pop(tx_pop),
        .din(tx_din),
        .dout(tx_dout),
        .empty(tx_empty),
        .full(tx_full),
        .count(tx_cnt),
        .count_next(tx_cnt_nx),
        .overflow(tx_ovf)
    );

    logic unused_sig;
    assign unused_sig = ^{mem_a[31:18], rx_full, rx_cnt, rx_cnt_nx,
                          tx_full, tx_cnt};

    assign mem_din = mem_din_q;
    assign rdy_out = rdy_q;
    assign tx_data = tx_dout;
    assign tx_valid = !tx_empty;
    assign halt = halt_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic        err_overflow;

    int ntests = 0;
    int nfail = 0;
    logic [7:0] txq [$];
    logic [31:0] tb_cyc;

    mem_io_responder dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .mem_a(mem_a),
        .mem_dout(mem_dout),
        .mem_wr(mem_wr),
        .mem_din(mem_din),
        .rdy_out(rdy_out),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .halt(halt),
        .err_overflow(err_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Expected cycle count: cycles elapsed since reset was released
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) tb_cyc <= 32'd0;
        else tb_cyc <= tb_cyc + 32'd1;
    end

    always @(negedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic [7:0] d,
                       input logic w);
        mem_a = a;
        mem_dout = d;
        mem_wr = w;
    endtask

    task automatic idle();
        bus(32'h0, 8'h00, 1'b0);
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data = d;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_cnt;
        int n41;
        rst_in = 1'b1;
        idle();
        rx_data = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        #12;
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_rdy", rdy_out, 1'b1);
        check("rst_halt", halt, 1'b0);
        check("rst_err", err_overflow, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        cyc();
        rst_in = 1'b0;
        bus(32'h0, 8'h00, 1'b1);
        cyc();

        // RAM write then read-after-write
        bus(32'h10, 8'hA5, 1'b1);
        cyc();
        bus(32'h10, 8'h00, 1'b0);
        cyc();
        idle();
        cyc();
        check("ram_a5", mem_din, 8'hA5);
        bus(32'h1FFFF, 8'h3C, 1'b1);
        cyc();
        bus(32'h1FFFF, 8'h00, 1'b0);
        cyc();
        bus(32'h30002, 8'h00, 1'b0);
        cyc();
        check("ram_top", mem_din, 8'h3C);
        idle();
        cyc();
        check("io_unmapped", mem_din, 8'h00);

        // TX with zero byte suppressed
        txq.delete();
        tx_ready = 1'b1;
        bus(32'h30000, 8'h48, 1'b1);
        cyc();
        check("tx_head_h", tx_data, 8'h48);
        bus(32'h30000, 8'h00, 1'b1);
        cyc();
        bus(32'h30000, 8'h69, 1'b1);
        cyc();
        idle();
        repeat (4) cyc();
        check("tx_len", txq.size(), 2);
        check("tx_b0", txq[0], 8'h48);
        check("tx_b1", txq[1], 8'h69);
        check("tx_drained", tx_valid, 1'b0);

        // Flow control with a stalled transmitter
        tx_ready = 1'b0;
        txq.delete();
        for (int k = 1; k <= 16; k++) begin
            bus(32'h30000, 8'h41, 1'b1);
            cyc();
            if (k == 14) check("rdy_at_14", rdy_out, 1'b1);
            if (k == 15) check("rdy_at_15", rdy_out, 1'b0);
        end
        idle();
        cyc();
        check("flow_no_ovf", err_overflow, 1'b0);
        check("flow_rdy_low", rdy_out, 1'b0);
        tx_ready = 1'b1;
        repeat (20) cyc();
        n41 = 0;
        foreach (txq[i]) if (txq[i] == 8'h41) n41++;
        check("flow_len", txq.size(), 16);
        check("flow_bytes", n41, 16);
        check("flow_rdy_up", rdy_out, 1'b1);
        check("flow_empty", tx_valid, 1'b0);

        // RX FIFO reads and overflow
        rx_push(8'h31);
        rx_push(8'h32);
        bus(32'h30000, 8'h00, 1'b0);
        cyc();
        bus(32'h30000, 8'h00, 1'b0);
        cyc();
        check("rx_b0", mem_din, 8'h31);
        bus(32'h30000, 8'h00, 1'b0);
        cyc();
        check("rx_b1", mem_din, 8'h32);
        idle();
        cyc();
        check("rx_empty", mem_din, 8'h00);
        for (int i = 0; i < 16; i++) rx_push(8'(i + 1));
        check("rx_full_no_ovf", err_overflow, 1'b0);
        rx_push(8'hEE);
        check("rx_ovf", err_overflow, 1'b1);

        // Coherent counter read
        repeat (1000) cyc();
        exp_cnt = tb_cyc;
        bus(32'h30004, 8'h00, 1'b0);
        cyc();
        bus(32'h30005, 8'h00, 1'b0);
        cyc();
        check("cnt_b0", mem_din, exp_cnt[7:0]);
        bus(32'h30006, 8'h00, 1'b0);
        cyc();
        check("cnt_b1", mem_din, exp_cnt[15:8]);
        bus(32'h30007, 8'h00, 1'b0);
        cyc();
        check("cnt_b2", mem_din, exp_cnt[23:16]);
        idle();
        cyc();
        check("cnt_b3", mem_din, exp_cnt[31:24]);

        // Counter wrap
        @(negedge clk_in);
        force dut.cyc_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_q;
        bus(32'h30004, 8'h00, 1'b0);
        cyc();
        bus(32'h30005, 8'h00, 1'b0);
        cyc();
        check("wrap_b0", mem_din, 8'hFF);
        bus(32'h30004, 8'h00, 1'b0);
        cyc();
        check("wrap_b1", mem_din, 8'hFF);
        bus(32'h30007, 8'h00, 1'b0);
        cyc();
        check("wrap_cnt_b0", mem_din, 8'h01);
        idle();
        cyc();
        check("wrap_cnt_b3", mem_din, 8'h00);

        // Halt with end marker
        txq.delete();
        bus(32'h30004, 8'h5A, 1'b1);
        cyc();
        check("halt_set", halt, 1'b1);
        check("halt_tx_valid", tx_valid, 1'b1);
        check("halt_marker", tx_data, 8'h00);
        idle();
        repeat (3) cyc();
        check("halt_tx_len", txq.size(), 1);
        check("halt_tx_b0", txq[0], 8'h00);
        check("halt_sticky", halt, 1'b1);

        // Asynchronous reset in the middle of a read
        tx_ready = 1'b0;
        bus(32'h30000, 8'h55, 1'b1);
        cyc();
        bus(32'h20, 8'h77, 1'b1);
        cyc();
        bus(32'h20, 8'h00, 1'b0);
        cyc();
        idle();
        cyc();
        check("pre_rst_din", mem_din, 8'h77);
        check("pre_rst_txv", tx_valid, 1'b1);
        bus(32'h20, 8'h00, 1'b0);
        cyc();
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_din", mem_din, 8'h00);
        check("arst_halt", halt, 1'b0);
        check("arst_txv", tx_valid, 1'b0);
        check("arst_err", err_overflow, 1'b0);
        check("arst_rdy", rdy_out, 1'b1);
        cyc();
        rst_in = 1'b0;
        idle();
        cyc();
        bus(32'h30000, 8'h00, 1'b0);
        cyc();
        idle();
        cyc();
        check("rx_lost", mem_din, 8'h00);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
